led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Drives the 4-bit LED bank with one of four animated patterns: bounce scan, rotate chase, blink and bar fill.
- Owns the step-rate prescaler, the pattern state machine and the mode selection.
- Sits between the board LEDs and upstream control: a debounced mode-step strobe, a speed select and a pause level.
- Replaces the single fixed-pattern scanner as the top-level LED owner.

Parameters:
- TICK_DIV, 20000000, clock cycles per pattern step at SPEED=0 (1 s at 20 MHz); must be ≥ 8.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST_N  input  1  asynchronous active-low reset.
- MODE_NEXT  input  1  one-cycle strobe, synchronous to CLK: advance to the next mode.
- SPEED  input  2  step period = TICK_DIV >> SPEED cycles (x1, x2, x4, x8 rate).
- PAUSE  input  1  level; freezes pattern stepping while high.
- LED  output  4  LED drive (bit 0 = rightmost).
- MODE  output  2  current mode: 0 SCAN, 1 CHASE, 2 BLINK, 3 FILL.
- TICK  output  1  one-cycle pulse, high in the cycle LED shows a newly stepped pattern.

Behaviour:
- Reset (async assert, sync release): MODE=0 (SCAN), LED=4'b0001, TICK=0, prescaler=0, scan direction=up.
- Prescaler:
  - TERM = (TICK_DIV >> SPEED) - 1, computed combinationally every cycle.
  - Counts 0..TERM while PAUSE=0. A step event occurs in the cycle where count ≥ TERM; the count then returns to 0.
  - The "≥" compare means a SPEED raise mid-period steps at the next edge and never runs past TERM.
- Step latency: LED and TICK update on the clock edge that ends the step-event cycle, so both are visible together one cycle after the terminal count. TICK is registered and is 0 in all other cycles.
- Pattern state machine, one transition per step event:
  - SCAN: 0001→0010→0100→1000→0100→0010→0001→0010…, period 6. Direction flips to down when the step lands on 1000 and to up when it lands on 0001. Endpoints are shown for exactly one step and never repeat.
  - CHASE: rotate left, 0001→0010→0100→1000→0001.
  - BLINK: 1111↔0000.
  - FILL: 0000→0001→0011→0111→1111→0000.
  - Any LED value not legal for the current mode (unreachable in normal operation) reloads that mode's start pattern at the next step.
- Mode change:
  - MODE_NEXT=1 advances MODE 0→1→2→3→0 (wraps) on that edge.
  - The same edge loads the new mode's start pattern: SCAN 0001, CHASE 0001, BLINK 1111, FILL 0000. It also clears the prescaler and sets scan direction to up. TICK stays 0.
- Simultaneous MODE_NEXT and step event: mode change wins, the step is discarded, no TICK.
- PAUSE=1: prescaler holds its value, no step events, LED frozen. MODE_NEXT is still honoured (reload and prescaler clear occur). Releasing PAUSE resumes counting from the held value.
- MODE_NEXT held high for N cycles advances N modes; debouncing is upstream's job.
- Reset asserted mid-step: all state returns to reset values immediately, with no partial pattern on LED.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: the LED port is the bitwise inverse of the internal pattern; reset value on the LED port is 4'b1110. MODE, TICK and all sequencing are unchanged.
- Undefined: the LED port equals the internal pattern (active-high).

Test Plan:
- Reset and SCAN bounce (TICK_DIV=8, SPEED=0): release RST_N → LED=0001, MODE=0. TICK every 8 cycles; LED sequence 0010,0100,1000,0100,0010,0001,0010.
- Speed (SPEED=2): TICK period 2 cycles. Switch SPEED 0→3 when prescaler=5 → step on the next edge, then period 1.
- Mode cycling (one MODE_NEXT strobe per phase):
  - MODE=1: LED 0001, then 0010, 0100, 1000, 0001.
  - MODE=2: LED 1111/0000 alternating.
  - MODE=3: LED 0000, 0001, 0011, 0111, 1111, 0000.
  - Fourth strobe: MODE=0, LED=0001.
- Collision: MODE_NEXT asserted in the terminal-count cycle → MODE advances, LED = new start pattern, TICK=0, next TICK 8 cycles later.
- Pause: PAUSE=1 at prescaler=3 for 20 cycles → LED constant, no TICK. Release → first TICK after 5 more cycles. MODE_NEXT during pause → MODE and LED update.
- Async reset mid-run (and LED_ACTIVE_LOW_EN build): RST_N low at an arbitrary non-edge time → LED=0001 (1110 with the macro), MODE=0, TICK=0 without waiting for CLK.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Four-pattern LED animator (scan, chase, blink, fill) with a speed-selectable step prescaler.
// Build option: define LED_ACTIVE_LOW_EN to drive LED as the bitwise inverse of the pattern.
module led_pattern_sequencer #(
  parameter int TICK_DIV = 20000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       MODE_NEXT,
  input  logic [1:0] SPEED,
  input  logic       PAUSE,
  output logic [3:0] LED,
  output logic [1:0] MODE,
  output logic       TICK
);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CHASE = 2'd1,
    BLINK = 2'd2,
    FILL  = 2'd3
  } mode_e;

  // The largest terminal count is TICK_DIV-1, so clog2(TICK_DIV) bits suffice.
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] term_tab [4];
  logic [CW-1:0] term;
  logic [CW-1:0] count_reg;
  mode_e         mode_reg;
  mode_e         mode_inc;
  logic [3:0]    pattern_reg;
  logic [3:0]    pattern_next;
  logic          dir_up_reg;
  logic          dir_up_next;
  logic          tick_reg;
  logic          step_evt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_term
      assign term_tab[gi] = CW'((TICK_DIV >> gi) - 1);
    end
  endgenerate

  assign term     = term_tab[SPEED];
  // ">=" lets a mid-period speed raise step immediately instead of wrapping.
  assign step_evt = !PAUSE && (count_reg >= term);
  assign mode_inc = mode_e'(mode_reg + 2'd1);

  function automatic logic [3:0] start_pattern(input mode_e m);
    case (m)
      BLINK:   start_pattern = 4'b1111;
      FILL:    start_pattern = 4'b0000;
      default: start_pattern = 4'b0001;
    endcase
  endfunction

  always_comb begin
    pattern_next = start_pattern(mode_reg);
    dir_up_next  = dir_up_reg;
    case (mode_reg)
      SCAN: begin
        case (pattern_reg)
          4'b0001: pattern_next = 4'b0010;
          4'b0010: pattern_next = dir_up_reg ? 4'b0100 : 4'b0001;
          4'b0100: pattern_next = dir_up_reg ? 4'b1000 : 4'b0010;
          4'b1000: pattern_next = 4'b0100;
          default: pattern_next = 4'b0001;
        endcase
        // Direction turns on landing at an endpoint so each end shows once.
        if (pattern_next == 4'b1000) begin
          dir_up_next = 1'b0;
        end else if (pattern_next == 4'b0001) begin
          dir_up_next = 1'b1;
        end
      end
      CHASE: begin
        case (pattern_reg)
          4'b0001, 4'b0010, 4'b0100, 4'b1000:
            pattern_next = {pattern_reg[2:0], pattern_reg[3]};
          default: pattern_next = 4'b0001;
        endcase
      end
      BLINK: begin
        case (pattern_reg)
          4'b1111: pattern_next = 4'b0000;
          4'b0000: pattern_next = 4'b1111;
          default: pattern_next = 4'b1111;
        endcase
      end
      FILL: begin
        case (pattern_reg)
          4'b0000: pattern_next = 4'b0001;
          4'b0001: pattern_next = 4'b0011;
          4'b0011: pattern_next = 4'b0111;
          4'b0111: pattern_next = 4'b1111;
          4'b1111: pattern_next = 4'b0000;
          default: pattern_next = 4'b0000;
        endcase
      end
      default: pattern_next = 4'b0001;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_reg    <= SCAN;
      pattern_reg <= 4'b0001;
      dir_up_reg  <= 1'b1;
      tick_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      tick_reg <= 1'b0;
      if (MODE_NEXT) begin
        // A mode change overrides any step event in the same cycle.
        mode_reg    <= mode_inc;
        pattern_reg <= start_pattern(mode_inc);
        dir_up_reg  <= 1'b1;
        count_reg   <= '0;
      end else if (!PAUSE) begin
        if (step_evt) begin
          pattern_reg <= pattern_next;
          dir_up_reg  <= dir_up_next;
          tick_reg    <= 1'b1;
          count_reg   <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign LED = ~pattern_reg;
`else
  assign LED = pattern_reg;
`endif
  assign MODE = mode_reg;
  assign TICK = tick_reg;

endmodule
